pte_barrier_queue: RTL

//   Registered, parametrised successor to the combinational PTE barrier. It buffers page-table

---
 rtl/pte_barrier_queue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pte_barrier_queue.sv
// -----------------------------------------------------------------------------
// pte_barrier_queue
//
// Purpose:
//   Registered FIFO that buffers page-table entries between the page-table
//   walker (producer, io_x_*) and the TLB refill path (consumer, io_y_*).
//   Each PTE is classified as it is enqueued. The leaf/fault flags are stored
//   next to the PTE, so the consumer sees them with no extra logic on the
//   head path. io_flush drops every buffered entry, for example on an sfence
//   or a PTW kill.
//
// Handshake (both sides):
//   A transfer happens on a rising clock edge when valid and ready are both
//   high in the cycle before that edge. Valid does not depend on ready.
//   io_x_ready is derived from the occupancy count only, so there is no
//   combinational path from io_y_ready to io_x_ready. A full queue therefore
//   refuses an enqueue even when a dequeue happens in the same cycle.
//   There is no bypass path: an entry enqueued at edge N first appears at the
//   head after edge N.
//
// Ports:
//   clock                  single clock; all state updates on posedge
//   reset                  synchronous, active-low
//   io_flush               drop all entries at the next edge
//   io_x_valid/ready       producer handshake (ready = !full)
//   io_x_ppn, io_x_d..v    incoming PTE fields
//   io_y_valid/ready       consumer handshake (valid = !empty)
//   io_y_ppn, io_y_d..v    head PTE fields
//   io_y_leaf              head is a leaf:      v & (r | x)
//   io_y_fault             head is malformed:   !v | (w & !r)
//   io_count               number of entries held
// -----------------------------------------------------------------------------
module pte_barrier_queue #(
    parameter int PPN_W = 54,
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_flush,
    input  logic                       io_x_valid,
    output logic                       io_x_ready,
    input  logic [PPN_W-1:0]           io_x_ppn,
    input  logic                       io_x_d,
    input  logic                       io_x_a,
    input  logic                       io_x_g,
    input  logic                       io_x_u,
    input  logic                       io_x_x,
    input  logic                       io_x_w,
    input  logic                       io_x_r,
    input  logic                       io_x_v,
    output logic                       io_y_valid,
    input  logic                       io_y_ready,
    output logic [PPN_W-1:0]           io_y_ppn,
    output logic                       io_y_d,
    output logic                       io_y_a,
    output logic                       io_y_g,
    output logic                       io_y_u,
    output logic                       io_y_x,
    output logic                       io_y_w,
    output logic                       io_y_r,
    output logic                       io_y_v,
    output logic                       io_y_leaf,
    output logic                       io_y_fault,
    output logic [$clog2(DEPTH+1)-1:0] io_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    // Entry layout, MSB first: ppn, d, a, g, u, x, w, r, v, leaf, fault
    localparam int ENT_W = PPN_W + 10;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Storage is deliberately not reset. Head data is don't-care while empty.
    logic [ENT_W-1:0] mem_q [DEPTH];

    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;
    logic             mem_we;
    logic             pte_leaf;
    logic             pte_fault;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head;

    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);

        // Classification depends only on the attribute bits. A pointer PTE
        // (v=1, r=w=x=0) is neither a leaf nor a fault.
        pte_leaf  = io_x_v & (io_x_r | io_x_x);
        pte_fault = ~io_x_v | (io_x_w & ~io_x_r);
        wr_entry  = {io_x_ppn, io_x_d, io_x_a, io_x_g, io_x_u,
                     io_x_x, io_x_w, io_x_r, io_x_v, pte_leaf, pte_fault};

        enq       = io_x_valid & ~full;
        deq       = io_y_ready & ~empty;

        // A flushed cycle still shows ready to the producer. The accepted
        // entry is dropped on purpose, so storage is not written.
        mem_we    = enq & ~io_flush & reset;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (io_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // The head is read combinationally from the entry at rd_ptr. It stays
    // stable while the consumer stalls because only a dequeue moves rd_ptr.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        io_y_ppn   = head[ENT_W-1 -: PPN_W];
        io_y_d     = head[9];
        io_y_a     = head[8];
        io_y_g     = head[7];
        io_y_u     = head[6];
        io_y_x     = head[5];
        io_y_w     = head[4];
        io_y_r     = head[3];
        io_y_v     = head[2];
        io_y_leaf  = head[1];
        io_y_fault = head[0];
        io_x_ready = ~full;
        io_y_valid = ~empty;
        io_count   = count_q;
    end

endmodule
